// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types for sram_arbiter (FSM state encoding, default widths, latched phy command)
package sram_arb_pkg;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;
  } mem_cmd_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: 2-way picker; req[1:0], last_grant, fixed_prio in -> grant_valid, grant_id out
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic       grant_valid,
  output logic       grant_id
);
  assign grant_valid = |req;
  assign grant_id = &req ? !fixed_prio && !last_grant : req[1];
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port req/ack arbiter onto one async SRAM phy; r0_*/r1_* requesters, mem_* phy side, busy/owner status
module sram_arbiter #(
  parameter int ADDR_W     = sram_arb_pkg::ADDR_W,
  parameter int DATA_W     = sram_arb_pkg::DATA_W,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [1:0]        r0_be,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic [1:0]        r1_be,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  import sram_arb_pkg::*;
  localparam int CW = TIMEOUT > 255 ? $clog2(TIMEOUT + 1) : 8;
  state_t state, state_nxt;
  mem_cmd_t cmd;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] rdata;
  logic err, last_grant, grant_valid, grant_id, expired;
  rr_pick2 u_pick (
    .req(        {r1_req, r0_req}),
    .last_grant( last_grant),
    .fixed_prio( FIXED_PRIO != 0),
    .grant_valid(grant_valid),
    .grant_id(   grant_id)
  );
  // cnt counts completed BUSY cycles, so expiry leaves exactly TIMEOUT cycles of mem_req
  assign expired = TIMEOUT != 0 && cnt + 1'b1 == CW'(TIMEOUT);
  assign mem_we = cmd.we;
  assign mem_addr = cmd.addr;
  assign mem_wdata = cmd.wdata;
  assign mem_be = cmd.be;
  always_comb begin
    state_nxt = state == IDLE ? (grant_valid ? BUSY : IDLE) :
                state == BUSY ? (mem_ack || expired ? RESP : BUSY) : IDLE;
    mem_req = state == BUSY;
    busy = state != IDLE;
    r0_ack = state == RESP && !owner;
    r1_ack = state == RESP && owner;
    r0_rdata = r0_ack ? rdata : '0;
    r1_rdata = r1_ack ? rdata : '0;
    r0_err = r0_ack && err;
    r1_err = r1_ack && err;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cmd <= '0;
      owner <= 1'b0;
      last_grant <= 1'b1;
      cnt <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_valid) begin
        cmd <= grant_id ? mem_cmd_t'{r1_we, r1_addr, r1_wdata, r1_be}
                        : mem_cmd_t'{r0_we, r0_addr, r0_wdata, r0_be};
        owner <= grant_id;
        last_grant <= grant_id;
        cnt <= '0;
      end
      // rdata/err only reach the ports in RESP, so refreshing them every BUSY cycle is harmless
      if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        rdata <= mem_ack && !cmd.we ? mem_rdata : '0;
        err <= !mem_ack;
      end
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: random + directed bench for sram_arbiter, round-robin and fixed-priority instances vs a reference model
module tb_sram_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [1:0] req, we;
  logic [17:0] addr [2];
  logic [15:0] wdata [2];
  logic [1:0] be [2];
  logic mem_ack;
  logic [15:0] mem_rdata;
  logic [1:0] mem_req_o, mem_we_o, busy_o, owner_o;
  logic [17:0] mem_addr_o [2];
  logic [15:0] mem_wdata_o [2];
  logic [1:0] mem_be_o [2];
  logic [1:0] ack_o [2];
  logic [1:0] err_o [2];
  logic [15:0] rdata_o [2][2];
  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_arbiter #(.FIXED_PRIO(g), .TIMEOUT(TO)) u (
      .clk(clk), .rst(rst),
      .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]), .r0_be(be[0]),
      .r0_ack(ack_o[g][0]), .r0_rdata(rdata_o[g][0]), .r0_err(err_o[g][0]),
      .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]), .r1_be(be[1]),
      .r1_ack(ack_o[g][1]), .r1_rdata(rdata_o[g][1]), .r1_err(err_o[g][1]),
      .mem_req(mem_req_o[g]), .mem_we(mem_we_o[g]), .mem_addr(mem_addr_o[g]),
      .mem_wdata(mem_wdata_o[g]), .mem_be(mem_be_o[g]),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .busy(busy_o[g]), .owner(owner_o[g])
    );
  end
  bit m_busy [2], m_resp [2], m_owner [2], m_last [2], m_we [2], m_err [2];
  logic [17:0] m_addr [2];
  logic [15:0] m_wdata [2], m_rd [2];
  logic [1:0] m_be [2];
  int m_wait [2];
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // instance i is fixed-priority when i == 1; predicts state after the coming edge
  task automatic model_step(input int i);
    if (rst) begin
      m_busy[i] = 0; m_resp[i] = 0; m_owner[i] = 0; m_last[i] = 1; m_we[i] = 0;
      m_addr[i] = '0; m_wdata[i] = '0; m_be[i] = '0; m_rd[i] = '0; m_err[i] = 0;
    end else if (m_resp[i]) m_resp[i] = 0;
    else if (m_busy[i]) begin
      m_wait[i]++;
      if (mem_ack || m_wait[i] == TO) begin
        m_busy[i] = 0; m_resp[i] = 1; m_err[i] = !mem_ack;
        m_rd[i] = mem_ack && !m_we[i] ? mem_rdata : 16'h0;
      end
    end else if (req != 2'b00) begin
      int p;
      p = req == 2'b11 ? (i == 1 ? 0 : int'(!m_last[i])) : int'(req[1]);
      m_owner[i] = p[0]; m_last[i] = p[0];
      m_we[i] = we[p]; m_addr[i] = addr[p]; m_wdata[i] = wdata[p]; m_be[i] = be[p];
      m_busy[i] = 1; m_wait[i] = 0;
    end
  endtask
  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      string s;
      s = $sformatf("u%0d.", i);
      check({s, "mem_req"}, mem_req_o[i], m_busy[i]);
      check({s, "mem_we"}, mem_we_o[i], m_we[i]);
      check({s, "mem_addr"}, mem_addr_o[i], m_addr[i]);
      check({s, "mem_wdata"}, mem_wdata_o[i], m_wdata[i]);
      check({s, "mem_be"}, mem_be_o[i], m_be[i]);
      check({s, "busy"}, busy_o[i], m_busy[i] || m_resp[i]);
      check({s, "owner"}, owner_o[i], m_owner[i]);
      for (int p = 0; p < 2; p++) begin
        bit a;
        a = m_resp[i] && m_owner[i] == p[0];
        check($sformatf("%sr%0d_ack", s, p), ack_o[i][p], a);
        check($sformatf("%sr%0d_rdata", s, p), rdata_o[i][p], a ? m_rd[i] : 16'h0);
        check($sformatf("%sr%0d_err", s, p), err_o[i][p], a && m_err[i]);
      end
    end
  endtask
  task automatic tick();
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare_all();
  endtask
  initial begin
    int n, got0[$], got1[$];
    bit seen;
    rst = 1; req = '0; we = '0; mem_ack = 0; mem_rdata = '0;
    for (int p = 0; p < 2; p++) begin addr[p] = '0; wdata[p] = '0; be[p] = '0; end
    tick();
    check("rst.busy", busy_o, 2'b00);
    check("rst.mem_req", mem_req_o, 2'b00);
    rst = 0;
    req[0] = 1; we[0] = 0; addr[0] = 18'h00010;
    tick();
    check("rd.latency", mem_req_o[0], 1);
    check("rd.addr", mem_addr_o[0], 18'h00010);
    tick(); tick();
    mem_ack = 1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 0; req[0] = 0;
    check("rd.ack", ack_o[0], 2'b01);
    check("rd.rdata", rdata_o[0][0], 16'hBEEF);
    check("rd.err", err_o[0][0], 0);
    tick();
    req[1] = 1; we[1] = 1; addr[1] = 18'h3FFFF; wdata[1] = 16'h1234; be[1] = 2'b10; mem_rdata = 16'hFFFF;
    tick();
    wdata[1] = 16'h5555; addr[1] = 18'h0;
    for (int k = 0; k < 3; k++) begin
      check("wr.addr", mem_addr_o[0], 18'h3FFFF);
      check("wr.wdata", mem_wdata_o[0], 16'h1234);
      check("wr.be", mem_be_o[0], 2'b10);
      if (k < 2) tick();
    end
    mem_ack = 1;
    tick();
    mem_ack = 0; req[1] = 0;
    check("wr.ack", ack_o[0], 2'b10);
    check("wr.rdata", rdata_o[0][1], 16'h0);
    tick();
    req[0] = 1; we[0] = 0; addr[0] = 18'h00123;
    n = 0; seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) req[0] = 0;
      if (ack_o[0][0]) begin seen = 1; break; end
      n += int'(mem_req_o[0]);
    end
    check("to.acked", seen, 1);
    check("to.cycles", n, TO);
    check("to.err", err_o[0][0], 1);
    check("to.rdata", rdata_o[0][0], 16'h0);
    tick();
    req[0] = 1; mem_rdata = 16'hA5A5;
    tick();
    req[0] = 0;
    tick(); tick(); tick();
    mem_ack = 1;
    tick();
    mem_ack = 0;
    check("tie.ack", ack_o[0][0], 1);
    check("tie.err", err_o[0][0], 0);
    check("tie.rdata", rdata_o[0][0], 16'hA5A5);
    tick();
    req[0] = 1;
    tick();
    req[0] = 0;
    tick();
    check("rb.mem_req", mem_req_o[0], 1);
    rst = 1;
    tick();
    rst = 0;
    check("rb.mem_req0", mem_req_o[0], 0);
    check("rb.busy", busy_o[0], 0);
    check("rb.ack", ack_o[0], 2'b00);
    mem_ack = 1;
    tick();
    check("rb.late_busy", busy_o[0], 0);
    check("rb.late_ack", ack_o[0], 2'b00);
    req = 2'b11;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (mem_req_o[0]) got0.push_back(int'(owner_o[0]));
      if (mem_req_o[1]) got1.push_back(int'(owner_o[1]));
    end
    req = 2'b00; mem_ack = 0;
    tick();
    check("alt.rr_n", got0.size(), 4);
    check("alt.fp_n", got1.size(), 4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("alt.rr%0d", j), got0.size() > j ? got0[j] : 9, j % 2);
      check($sformatf("alt.fp%0d", j), got1.size() > j ? got1[j] : 9, 0);
    end
    for (int k = 0; k < 2000; k++) begin
      rst = $urandom_range(99) == 0;
      req = {$urandom_range(9) < 6, $urandom_range(9) < 6};
      we = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        addr[p] = 18'($urandom); wdata[p] = 16'($urandom); be[p] = 2'($urandom);
      end
      mem_ack = $urandom_range(9) < 3;
      mem_rdata = 16'($urandom);
      tick();
    end
    rst = 1;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
